regfile_nxm: RTL and testbench

- Parametrised register file built from edge-triggered, enable-gated word registers. Generalises the fixed 32-bit enable register to NUM_REGS words of WIDTH bits.
- One synchronous write port with byte-lane mask, two independent combinational read ports, a synchronous clear, and optional write-to-read bypass.
- Serves as the datapath register bank between decode and the ALU.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_nxm_if.sv | 31 +++
 rtl/reg_word.sv | 39 +++
 rtl/regfile_nxm.sv | 91 +++++++++
 tb/tb_regfile_nxm.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the byte-lane register file.
package regfile_pkg;

  localparam int REG_ZERO_IDX  = 0;
  localparam int DEFAULT_WIDTH = 32;

  function automatic int LANES(input int width);
    return width / 8;
  endfunction

  typedef logic [DEFAULT_WIDTH/8-1:0] mask_t;

endpackage

// File: rtl/regfile_nxm_if.sv
// Write/read bus of the register file; decode drives it as master.
interface regfile_nxm_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);

  localparam int LN = WIDTH / 8;

  logic              enable;
  logic              clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [LN-1:0]     wr_mask;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic              wr_ack;

  modport master (
    output enable, clear, wr_en, wr_addr, wr_data, wr_mask, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_ack
  );

  modport slave (
    input  enable, clear, wr_en, wr_addr, wr_data, wr_mask, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_ack
  );

endinterface

// File: rtl/reg_word.sv
// One register word with per-byte-lane load, sync clear and async reset.
module reg_word
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic                    i_clear,
  input  logic [LANES(WIDTH)-1:0] i_load,
  input  logic [WIDTH-1:0]        i_data,
  output logic [WIDTH-1:0]        o_q
);

  localparam int LN = LANES(WIDTH);

  logic [WIDTH-1:0] r_q;

  // Clear beats lane loads; a frozen enable holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_enable) begin
      if (i_clear) begin
        r_q <= {WIDTH{1'b0}};
      end else begin
        for (int i = 0; i < LN; i++) begin
          if (i_load[i]) begin
            r_q[8*i +: 8] <= i_data[8*i +: 8];
          end
        end
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_nxm.sv
// NUM_REGS x WIDTH register file: one masked write port, two combinational
// read ports with optional write-to-read bypass, and a registered write ack.
module regfile_nxm
  import regfile_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int NUM_REGS  = 32,
  parameter  int ZERO_REG0 = 1,
  parameter  int BYPASS    = 1,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic         clk,
  input  logic         reset,
  regfile_nxm_if.slave bus
);

  localparam int LN = LANES(WIDTH);

  logic [WIDTH-1:0] w_store [NUM_REGS];
  logic             w_wr_live;
  logic             r_wr_ack;

  assign w_wr_live = bus.enable && !bus.clear && bus.wr_en;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
    if ((ZERO_REG0 != 0) && (g == REG_ZERO_IDX)) begin : g_zero
      assign w_store[g] = {WIDTH{1'b0}};
    end else begin : g_reg
      logic [LN-1:0] w_load;
      assign w_load = (bus.wr_en && (bus.wr_addr == ADDR_W'(g))) ? bus.wr_mask : {LN{1'b0}};
      reg_word #(.WIDTH(WIDTH)) u_word (
        .clk      (clk),
        .rst      (reset),
        .i_enable (bus.enable),
        .i_clear  (bus.clear),
        .i_load   (w_load),
        .i_data   (bus.wr_data),
        .o_q      (w_store[g])
      );
    end
  end

  // Bypass merges the live write lanes over the stored word; reset forces 0.
  function automatic logic [WIDTH-1:0] read_word(
    input logic              rst_in,
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  stored,
    input logic              live,
    input logic [ADDR_W-1:0] waddr,
    input logic [WIDTH-1:0]  wdata,
    input logic [LN-1:0]     wmask
  );
    logic [WIDTH-1:0] v;
    v = stored;
    if (rst_in) begin
      v = {WIDTH{1'b0}};
    end else if ((ZERO_REG0 != 0) && (addr == ADDR_W'(REG_ZERO_IDX))) begin
      v = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && live && (addr == waddr)) begin
      for (int i = 0; i < LN; i++) begin
        if (wmask[i]) begin
          v[8*i +: 8] = wdata[8*i +: 8];
        end else begin
          v[8*i +: 8] = stored[8*i +: 8];
        end
      end
    end else begin
      v = stored;
    end
    return v;
  endfunction

  assign bus.rd_data_a = read_word(reset, bus.rd_addr_a, w_store[bus.rd_addr_a],
                                   w_wr_live, bus.wr_addr, bus.wr_data, bus.wr_mask);
  assign bus.rd_data_b = read_word(reset, bus.rd_addr_b, w_store[bus.rd_addr_b],
                                   w_wr_live, bus.wr_addr, bus.wr_data, bus.wr_mask);

  // Ack every committed write, including empty-mask and word-0 no-ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ack <= 1'b0;
    end else if (!bus.enable || bus.clear) begin
      r_wr_ack <= 1'b0;
    end else begin
      r_wr_ack <= bus.wr_en;
    end
  end

  assign bus.wr_ack = r_wr_ack;

endmodule

// File: tb/tb_regfile_nxm.sv
// Scoreboard bench: default 32x32 file plus a 16-bit x 8 file without
// word-0 forcing or bypass, both driven from one stimulus stream.
module tb_regfile_nxm;
  import regfile_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_nxm_if #(.WIDTH(32), .ADDR_W(5)) bus  ();
  regfile_nxm_if #(.WIDTH(16), .ADDR_W(3)) bus2 ();

  assign bus2.enable    = bus.enable;
  assign bus2.clear     = bus.clear;
  assign bus2.wr_en     = bus.wr_en;
  assign bus2.wr_addr   = bus.wr_addr[2:0];
  assign bus2.wr_data   = bus.wr_data[15:0];
  assign bus2.wr_mask   = bus.wr_mask[1:0];
  assign bus2.rd_addr_a = bus.rd_addr_a[2:0];
  assign bus2.rd_addr_b = bus.rd_addr_b[2:0];

  regfile_nxm u_dut (.clk(clk), .reset(reset), .bus(bus.slave));
  regfile_nxm #(.WIDTH(16), .NUM_REGS(8), .ZERO_REG0(0), .BYPASS(0))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  typedef struct {
    int          cyc;
    logic [31:0] a, b;
    logic        ack;
    logic [15:0] a2, b2;
    logic        ack2;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] m1[32];
  logic [15:0] m2[8];
  logic        ack1_m = 1'b0;
  logic        ack2_m = 1'b0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m1[i] = 32'h0;
    for (int i = 0; i < 8; i++) m2[i] = 16'h0;
  endtask

  function automatic logic [31:0] rd1(logic [4:0] a, bit live);
    logic [31:0] v;
    if (reset || a == 5'd0) return 32'h0;
    v = m1[a];
    if (live && a == bus.wr_addr) v = merge(v, bus.wr_data, bus.wr_mask);
    return v;
  endfunction

  function automatic logic [15:0] rd2(logic [2:0] a);
    if (reset) return 16'h0;
    return m2[a];
  endfunction

  // Predict outputs for the current inputs, then advance the model over the edge.
  task automatic step();
    exp_t        e;
    bit          live;
    logic [31:0] t;
    if (reset) begin
      model_clear();
      ack1_m = 1'b0;
      ack2_m = 1'b0;
    end
    live   = bus.enable && !bus.clear && bus.wr_en;
    e.cyc  = cyc;
    e.a    = rd1(bus.rd_addr_a, live);
    e.b    = rd1(bus.rd_addr_b, live);
    e.ack  = reset ? 1'b0 : ack1_m;
    e.a2   = rd2(bus.rd_addr_a[2:0]);
    e.b2   = rd2(bus.rd_addr_b[2:0]);
    e.ack2 = reset ? 1'b0 : ack2_m;
    sb.push_back(e);
    @(posedge clk);
    if (reset) begin
      model_clear();
      ack1_m = 1'b0;
    end else if (!bus.enable) begin
      ack1_m = 1'b0;
    end else if (bus.clear) begin
      model_clear();
      ack1_m = 1'b0;
    end else if (bus.wr_en) begin
      if (bus.wr_addr != 5'd0) m1[bus.wr_addr] = merge(m1[bus.wr_addr], bus.wr_data, bus.wr_mask);
      t = merge({16'h0, m2[bus.wr_addr[2:0]]}, bus.wr_data, {2'b00, bus.wr_mask[1:0]});
      m2[bus.wr_addr[2:0]] = t[15:0];
      ack1_m = 1'b1;
    end else begin
      ack1_m = 1'b0;
    end
    ack2_m = ack1_m;
    #1;
    cyc++;
  endtask

  task automatic drv(bit rs, bit en, bit cl, bit we, logic [4:0] wa, logic [31:0] wd,
                     mask_t wm, logic [4:0] ra, logic [4:0] rb);
    reset         = rs;
    bus.enable    = en;
    bus.clear     = cl;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.wr_mask   = wm;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    step();
  endtask

  task automatic chk(string n, int c, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%h required=%h", n, c, act, req);
    end
  endtask

  // Monitor: compare each presented output set against the queued prediction.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rd_a",   e.cyc, bus.rd_data_a,          e.a);
      chk("rd_b",   e.cyc, bus.rd_data_b,          e.b);
      chk("ack",    e.cyc, {31'h0, bus.wr_ack},    {31'h0, e.ack});
      chk("rd_a16", e.cyc, {16'h0, bus2.rd_data_a}, {16'h0, e.a2});
      chk("rd_b16", e.cyc, {16'h0, bus2.rd_data_b}, {16'h0, e.b2});
      chk("ack16",  e.cyc, {31'h0, bus2.wr_ack},   {31'h0, e.ack2});
    end
  end

  initial begin
    logic [4:0] wa;
    bus.enable = 1'b0; bus.clear = 1'b0; bus.wr_en = 1'b0;
    bus.wr_addr = 5'd0; bus.wr_data = 32'h0; bus.wr_mask = 4'h0;
    bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd0;
    model_clear();
    @(posedge clk);
    #1;
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd7);
    // full then masked write to r3
    drv(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h11223344, 4'hF, 5'd3, 5'd3);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'hAABBCCDD, 4'h5, 5'd3, 5'd0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd3);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd1);
    // word 0
    drv(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0);
    // bypass on r7
    drv(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h00000001, 4'hF, 5'd1, 5'd2);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h000000FF, 4'h1, 5'd7, 5'd7);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7);
    // enable low freezes, then clear beats write
    drv(1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h00000005, 4'hF, 5'd2, 5'd2);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h00000077, 4'hF, 5'd2, 5'd3);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd2, 5'd3);
    drv(1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h00000099, 4'hF, 5'd2, 5'd3);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd2, 5'd3);
    // empty-mask write is still acked
    drv(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h12345678, 4'h0, 5'd4, 5'd4);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd4, 5'd4);
    // upper lane only on the 16-bit file, then every word of it
    drv(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000BEEF, 4'h2, 5'd7, 5'd7);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7);
    for (int i = 0; i < 8; i++) begin
      wa = 5'(i);
      drv(1'b0, 1'b1, 1'b0, 1'b1, wa, 32'hA5A50000 + 32'(i * 257), 4'hF, 5'd0, 5'd0);
    end
    for (int i = 0; i < 8; i++) begin
      wa = 5'(i);
      drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, wa, 5'(7 - i));
    end
    // reset asserted mid-write
    drv(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd5);
    drv(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd5);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5);
    // randomized traffic, biased towards read-after-write collisions
    for (int n = 0; n < 800; n++) begin
      logic [4:0] ra, rb;
      wa = 5'($urandom_range(31, 0));
      ra = ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0));
      rb = ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0));
      drv(($urandom_range(63, 0) == 0), ($urandom_range(7, 0) != 0),
          ($urandom_range(31, 0) == 0), ($urandom_range(2, 0) != 0),
          wa, $urandom, 4'($urandom_range(15, 0)), ra, rb);
    end
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
